// File: rtl/mw_pipe_reg_pkg.sv
// Shared definitions for the M->W pipeline register: load-extension encodings,
// reset PC value and the registered W-stage payload.
package mw_pipe_reg_pkg;

  localparam logic [2:0]  LD_WORD   = 3'b000;
  localparam logic [2:0]  LD_BU     = 3'b001;
  localparam logic [2:0]  LD_B      = 3'b010;
  localparam logic [2:0]  LD_HU     = 3'b011;
  localparam logic [2:0]  LD_H      = 3'b100;

  localparam logic [31:0] RESET_PC8 = 32'h0000_3008;

  typedef struct packed {
    logic [31:0] md;
    logic [31:0] memory;
    logic [31:0] result;
    logic [31:0] pcn8;
    logic        reg_write;
    logic [4:0]  a3;
    logic [31:0] op;
  } mw_dat_t;

endpackage

// File: rtl/mw_pipe_reg_load_ext.sv
// load_ext: byte/halfword select and sign/zero extension of a raw load word.
// Latency: combinational. Backpressure: none (pure function of inputs).
module load_ext
  import mw_pipe_reg_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  ld_type,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    case (addr)
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    // addr[0] is don't-care for halfwords; misalignment is trapped upstream
    h = addr[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (ld_type)
      LD_BU:   data = {24'b0, b};
      LD_B:    data = {{24{b[7]}}, b};
      LD_HU:   data = {16'b0, h};
      LD_H:    data = {{16{h[15]}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mw_pipe_reg.sv
// mw_pipe_reg: M->W pipeline register with load extension; MW_RETIRE_CNT_EN adds retire_cnt.
// Latency: 1 cycle. Backpressure: en_W=0 holds every register; req overrides hold with a bubble.
module mw_pipe_reg #(
  parameter int          DW        = 32,
  parameter logic [31:0] RESET_PC8 = mw_pipe_reg_pkg::RESET_PC8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_W,
  input  logic          req,
  input  logic [DW-1:0] md_M_o,
  input  logic [DW-1:0] dm_rdata_M,
  input  logic [1:0]    dm_addr_M,
  input  logic [2:0]    ld_type_M,
  input  logic [DW-1:0] result_M_o,
  input  logic [DW-1:0] PCn8_M_o,
  input  logic          regWrite_M_o,
  input  logic [4:0]    A3_M_o,
  input  logic [DW-1:0] OP_M_o,
  output logic [DW-1:0] md_W_i,
  output logic [DW-1:0] memory_W_i,
  output logic [DW-1:0] result_W_i,
  output logic [DW-1:0] PCn8_W_i,
  output logic          regWrite_W_i,
  output logic [4:0]    A3_W_i,
  output logic [DW-1:0] OP_W_i,
  output logic          valid_W
`ifdef MW_RETIRE_CNT_EN
  ,
  output logic [31:0]   retire_cnt
`endif
);
  import mw_pipe_reg_pkg::*;

  logic [DW-1:0] ld_data;
  mw_dat_t       w_q;

  load_ext u_load_ext (
    .rdata   (dm_rdata_M),
    .addr    (dm_addr_M),
    .ld_type (ld_type_M),
    .data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_q      <= '0;
      w_q.pcn8 <= RESET_PC8;
      valid_W  <= 1'b0;
    end else if (req) begin
      // bubble keeps PC+8 so the W-stage PC trace stays continuous
      w_q      <= '0;
      w_q.pcn8 <= PCn8_M_o;
      valid_W  <= 1'b0;
    end else if (en_W) begin
      w_q.md        <= md_M_o;
      w_q.memory    <= ld_data;
      w_q.result    <= result_M_o;
      w_q.pcn8      <= PCn8_M_o;
      w_q.reg_write <= regWrite_M_o & (A3_M_o != 5'd0);
      w_q.a3        <= A3_M_o;
      w_q.op        <= OP_M_o;
      valid_W       <= 1'b1;
    end
  end

  assign md_W_i       = w_q.md;
  assign memory_W_i   = w_q.memory;
  assign result_W_i   = w_q.result;
  assign PCn8_W_i     = w_q.pcn8;
  assign regWrite_W_i = w_q.reg_write;
  assign A3_W_i       = w_q.a3;
  assign OP_W_i       = w_q.op;

`ifdef MW_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      retire_cnt <= '0;
    end else if (!req && en_W && (OP_M_o != '0)) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mw_pipe_reg.sv
// Directed, table-driven bench for mw_pipe_reg: load extension vectors plus
// reset, hold, flush and (with MW_RETIRE_CNT_EN) retire counter sequences.
module tb_mw_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_W;
  logic        req;
  logic [31:0] md_M_o;
  logic [31:0] dm_rdata_M;
  logic [1:0]  dm_addr_M;
  logic [2:0]  ld_type_M;
  logic [31:0] result_M_o;
  logic [31:0] PCn8_M_o;
  logic        regWrite_M_o;
  logic [4:0]  A3_M_o;
  logic [31:0] OP_M_o;
  logic [31:0] md_W_i;
  logic [31:0] memory_W_i;
  logic [31:0] result_W_i;
  logic [31:0] PCn8_W_i;
  logic        regWrite_W_i;
  logic [4:0]  A3_W_i;
  logic [31:0] OP_W_i;
  logic        valid_W;
`ifdef MW_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mw_pipe_reg dut (
    .clk          (clk),
    .reset        (reset),
    .en_W         (en_W),
    .req          (req),
    .md_M_o       (md_M_o),
    .dm_rdata_M   (dm_rdata_M),
    .dm_addr_M    (dm_addr_M),
    .ld_type_M    (ld_type_M),
    .result_M_o   (result_M_o),
    .PCn8_M_o     (PCn8_M_o),
    .regWrite_M_o (regWrite_M_o),
    .A3_M_o       (A3_M_o),
    .OP_M_o       (OP_M_o),
    .md_W_i       (md_W_i),
    .memory_W_i   (memory_W_i),
    .result_W_i   (result_W_i),
    .PCn8_W_i     (PCn8_W_i),
    .regWrite_W_i (regWrite_W_i),
    .A3_W_i       (A3_W_i),
    .OP_W_i       (OP_W_i),
    .valid_W      (valid_W)
`ifdef MW_RETIRE_CNT_EN
    ,
    .retire_cnt   (retire_cnt)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  addr;
    logic [2:0]  ld_type;
    logic        rw;
    logic [4:0]  a3;
    logic [31:0] exp_mem;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one M-stage instruction (inputs change on the falling edge).
  task automatic drive(input logic [31:0] rdata, input logic [1:0] addr, input logic [2:0] lt,
                       input logic rw, input logic [4:0] a3, input logic [31:0] pc,
                       input logic [31:0] op, input logic [31:0] res, input logic [31:0] md);
    dm_rdata_M   = rdata;
    dm_addr_M    = addr;
    ld_type_M    = lt;
    regWrite_M_o = rw;
    A3_M_o       = a3;
    PCn8_M_o     = pc;
    OP_M_o       = op;
    result_M_o   = res;
    md_M_o       = md;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] md, input logic [31:0] mem,
                         input logic [31:0] res, input logic [31:0] pc, input logic rw,
                         input logic [4:0] a3, input logic [31:0] op, input logic v);
    chk({tag, ".md"},       md_W_i,       md);
    chk({tag, ".memory"},   memory_W_i,   mem);
    chk({tag, ".result"},   result_W_i,   res);
    chk({tag, ".pcn8"},     PCn8_W_i,     pc);
    chk({tag, ".regwrite"}, {31'b0, regWrite_W_i}, {31'b0, rw});
    chk({tag, ".a3"},       {27'b0, A3_W_i}, {27'b0, a3});
    chk({tag, ".op"},       OP_W_i,       op);
    chk({tag, ".valid"},    {31'b0, valid_W}, {31'b0, v});
  endtask

  initial begin
    vecs[0]  = '{32'h8899AABB, 2'd2, 3'b010, 1'b1, 5'd3,  32'hFFFFFF99, 1'b1};
    vecs[1]  = '{32'h8899AABB, 2'd2, 3'b001, 1'b1, 5'd4,  32'h00000099, 1'b1};
    vecs[2]  = '{32'h8899AABB, 2'd2, 3'b100, 1'b1, 5'd0,  32'hFFFF8899, 1'b0};
    vecs[3]  = '{32'h8899AABB, 2'd2, 3'b011, 1'b0, 5'd7,  32'h00008899, 1'b0};
    vecs[4]  = '{32'h8899AABB, 2'd2, 3'b000, 1'b1, 5'd5,  32'h8899AABB, 1'b1};
    vecs[5]  = '{32'h8899AABB, 2'd0, 3'b010, 1'b1, 5'd31, 32'hFFFFFFBB, 1'b1};
    vecs[6]  = '{32'h8899AABB, 2'd1, 3'b001, 1'b1, 5'd1,  32'h000000AA, 1'b1};
    vecs[7]  = '{32'h8899AABB, 2'd3, 3'b010, 1'b1, 5'd2,  32'hFFFFFF88, 1'b1};
    vecs[8]  = '{32'h8899AABB, 2'd0, 3'b100, 1'b1, 5'd6,  32'hFFFFAABB, 1'b1};
    vecs[9]  = '{32'h8899AABB, 2'd1, 3'b011, 1'b1, 5'd8,  32'h0000AABB, 1'b1};
    vecs[10] = '{32'h8899AABB, 2'd3, 3'b100, 1'b1, 5'd9,  32'hFFFF8899, 1'b1};
    vecs[11] = '{32'h12345678, 2'd3, 3'b010, 1'b1, 5'd10, 32'h00000012, 1'b1};
    vecs[12] = '{32'h12345678, 2'd0, 3'b100, 1'b0, 5'd0,  32'h00005678, 1'b0};
    vecs[13] = '{32'h12345678, 2'd1, 3'b101, 1'b1, 5'd11, 32'h12345678, 1'b1};
    vecs[14] = '{32'h12345678, 2'd2, 3'b111, 1'b1, 5'd12, 32'h12345678, 1'b1};
    vecs[15] = '{32'h0000807F, 2'd0, 3'b010, 1'b1, 5'd13, 32'h0000007F, 1'b1};

    // Reset held for two edges with busy inputs, en_W and req asserted.
    reset = 1'b0; en_W = 1'b1; req = 1'b1;
    drive(32'hDEADBEEF, 2'd1, 3'b010, 1'b1, 5'd9, 32'h5555_0000, 32'h1234_5678, 32'hCAFE_0000, 32'h0BAD_F00D);
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 32'h0, 32'h0, 32'h0, 32'h3008, 1'b0, 5'd0, 32'h0, 1'b0);
`ifdef MW_RETIRE_CNT_EN
    chk("reset.retire_cnt", retire_cnt, 32'h0);
`endif
    reset = 1'b1; req = 1'b0; en_W = 1'b0;
    @(negedge clk);
    chk("post_reset_hold.pcn8",  PCn8_W_i, 32'h3008);
    chk("post_reset_hold.valid", {31'b0, valid_W}, 32'h0);

    // Load-extension and regWrite normalisation table.
    en_W = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rdata, vecs[i].addr, vecs[i].ld_type, vecs[i].rw, vecs[i].a3,
            32'h3000 + 32'(4 * i), 32'h8C00_0000 + 32'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i));
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), 32'h2000 + 32'(i), vecs[i].exp_mem, 32'h1000 + 32'(i),
              32'h3000 + 32'(4 * i), vecs[i].exp_rw, vecs[i].a3, 32'h8C00_0000 + 32'(i), 1'b1);
    end

    // Stall: one load then three held cycles with changing inputs.
    drive(32'hA5A5A5A5, 2'd0, 3'b000, 1'b1, 5'd5, 32'h3010, 32'h8C05_0010, 32'h0000_0777, 32'h0000_0999);
    @(negedge clk);
    en_W = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(32'h1111_0000 + 32'(k), 2'(k), 3'(k), 1'b0, 5'(20 + k), 32'h4000 + 32'(k),
            32'hFFFF_0000 + 32'(k), 32'h6000 + 32'(k), 32'h7000 + 32'(k));
      @(negedge clk);
      chk_all($sformatf("hold%0d", k), 32'h0999, 32'hA5A5A5A5, 32'h0777, 32'h3010, 1'b1, 5'd5,
              32'h8C05_0010, 1'b1);
    end

    // Flush while stalled: bubble, but PC+8 still advances.
    req = 1'b1;
    drive(32'hFFFF_FFFF, 2'd3, 3'b010, 1'b1, 5'd17, 32'h3020, 32'h8C11_0000, 32'h5A5A_5A5A, 32'h3C3C_3C3C);
    @(negedge clk);
    chk_all("flush", 32'h0, 32'h0, 32'h0, 32'h3020, 1'b0, 5'd0, 32'h0, 1'b0);

    // Bubble must survive a subsequent hold.
    req = 1'b0;
    @(negedge clk);
    chk("flush_hold.valid", {31'b0, valid_W}, 32'h0);
    chk("flush_hold.pcn8",  PCn8_W_i, 32'h3020);

    // Reset beats req and en_W.
    reset = 1'b0; req = 1'b1; en_W = 1'b1;
    @(negedge clk);
    chk("reset_prio.pcn8",  PCn8_W_i, 32'h3008);
    chk("reset_prio.valid", {31'b0, valid_W}, 32'h0);
    reset = 1'b1; req = 1'b0;

`ifdef MW_RETIRE_CNT_EN
    // 4 retiring loads, 1 zero-OP load, 1 flush, 2 holds.
    en_W = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(32'h0, 2'd0, 3'b000, 1'b1, 5'd1, 32'h3100 + 32'(4 * k), 32'h0000_0021 + 32'(k), 32'h0, 32'h0);
      @(negedge clk);
    end
    OP_M_o = 32'h0;
    @(negedge clk);
    OP_M_o = 32'h8C00_0001; req = 1'b1;
    @(negedge clk);
    req = 1'b0; en_W = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("retire_cnt.count", retire_cnt, 32'd4);

    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    en_W = 1'b1;
    @(negedge clk);
    chk("retire_cnt.wrap", retire_cnt, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mw_pipe_reg.md
Name: mw_pipe_reg

Overview:
- Memory-to-Writeback pipeline register of the P7 five-stage MIPS core.
- Captures M-stage results each cycle and performs load-data extension (byte/halfword select, sign/zero extend) before registering.
- Its registered outputs drive the W stage directly.
- Supports stall hold and an exception/interrupt flush that inserts a bubble.

Parameters:
- DW, 32, datapath width (fixed at 32 for this core; parameter kept for readability only)
- RESET_PC8, 32'h0000_3008, value of PCn8_W_i after reset (reset PC 0x3000 + 8)

Ports:
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- en_W  input  1  load enable; 0 = hold all registers (stall)
- req  input  1  exception/interrupt flush request; 1 = next W contents become a bubble
- md_M_o  input  32  HI/LO read value from M
- dm_rdata_M  input  32  raw word read from data memory / bridge
- dm_addr_M  input  2  low two bits of the load byte address
- ld_type_M  input  3  load-extension selector (encoding in Behaviour)
- result_M_o  input  32  ALU/CP0 result from M
- PCn8_M_o  input  32  PC+8 of the M instruction
- regWrite_M_o  input  1  GRF write enable from M
- A3_M_o  input  5  GRF destination from M
- OP_M_o  input  32  instruction word from M
- md_W_i  output  32  registered md
- memory_W_i  output  32  registered, extended load data
- result_W_i  output  32  registered result
- PCn8_W_i  output  32  registered PC+8
- regWrite_W_i  output  1  registered write enable
- A3_W_i  output  5  registered destination
- OP_W_i  output  32  registered instruction
- valid_W  output  1  1 = W holds a real instruction, 0 = bubble

Behaviour:
- Reset: when reset==0 at a rising edge, all outputs are 0 except PCn8_W_i = RESET_PC8. valid_W is 0. Reset overrides en_W and req.
- Priority at each rising edge: reset > req > !en_W (hold) > load.
- Latency: one cycle from M inputs to W outputs.
- Load: all fields take their M values; valid_W = 1.
- regWrite normalisation: regWrite_W_i = regWrite_M_o & (A3_M_o != 0), so a $0 destination never asserts a write.
- Flush (req==1):
  - md, memory, result, OP and A3 become 0; regWrite_W_i = 0; valid_W = 0.
  - PCn8_W_i still loads PCn8_M_o, keeping the PC trace continuous.
  - req applies even when en_W==0.
- Hold (en_W==0, req==0): every register, including valid_W, keeps its value.
- Load extension (combinational, before the register); byte b = dm_rdata_M[8*dm_addr_M +: 8], halfword h = dm_rdata_M[16*dm_addr_M[1] +: 16]:
  - 3'b000 lw: word unchanged
  - 3'b001 lbu: zero-extend b
  - 3'b010 lb: sign-extend b
  - 3'b011 lhu: zero-extend h
  - 3'b100 lh: sign-extend h
  - 3'b101..3'b111: treated as lw
- For halfword loads dm_addr_M[0] is ignored; alignment exceptions are raised upstream.

Optional Feature:
- Macro: MW_RETIRE_CNT_EN
- With the macro: extra output retire_cnt [31:0].
  - Reset to 0.
  - Increments by 1 on every edge that performs a Load with OP_M_o != 0.
  - Unchanged on flush or hold.
  - Wraps 0xFFFF_FFFF -> 0.
- Without the macro: no port, no counter logic; all other behaviour identical.

Decomposition:
- Shared package / header: LD_WORD, LD_BU, LD_B, LD_HU, LD_H encodings, RESET_PC8.
- One combinational sub-module, load_ext (inputs rdata, addr[1:0], ld_type; output 32-bit extended data), instanced once.

Test Plan:
- reset=0 for 2 cycles, then release -> all outputs 0, PCn8_W_i=0x3008, valid_W=0 until the first load.
- dm_rdata_M=0x8899AABB, dm_addr_M=2 -> lb gives 0xFFFFFF99, lbu gives 0x00000099, lh gives 0xFFFF8899, lhu gives 0x00008899, lw gives 0x8899AABB, each one cycle later.
- regWrite_M_o=1, A3_M_o=0 -> regWrite_W_i=0, valid_W=1. With A3_M_o=5 -> regWrite_W_i=1, A3_W_i=5.
- Load instruction with PCn8_M_o=0x3010, then en_W=0 for 3 cycles with changing inputs -> outputs frozen at the first instruction.
- req=1 with en_W=0 and PCn8_M_o=0x3020 -> next cycle regWrite_W_i=0, OP_W_i=0, valid_W=0, PCn8_W_i=0x3020.
- With MW_RETIRE_CNT_EN: 4 loads, 1 flush, 2 holds -> retire_cnt=4. Force counter to 0xFFFFFFFF, then one load -> retire_cnt=0.
